// File: rtl/nios2e_pio_in.sv
// Avalon-MM input PIO: synchronises and optionally debounces an input bus,
// latches edges into write-1-to-clear capture bits and raises a maskable IRQ.

module nios2e_pio_in_lane #(
  parameter int EDGE_TYPE = 0,
  parameter bit DEBOUNCE  = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit_i,
  input  logic tick_i,
  input  logic clr_i,
  output logic deb_o,
  output logic cap_o
);
  logic s1_q, s2_q, deb, deb_d_q, cap_q, edge_det;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      deb_d_q <= 1'b0;
      cap_q   <= 1'b0;
    end else begin
      s1_q    <= in_bit_i;
      s2_q    <= s1_q;
      deb_d_q <= deb;
      // a new edge beats a simultaneous clear
      cap_q   <= edge_det | (cap_q & ~clr_i);
    end
  end

  generate
    if (DEBOUNCE) begin : g_deb
      logic prev_q, deb_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          prev_q <= 1'b0;
          deb_q  <= 1'b0;
        end else if (tick_i) begin
          prev_q <= s2_q;
          if (s2_q == prev_q) deb_q <= s2_q;
        end
      end
      assign deb = deb_q;
    end else begin : g_byp
      assign deb = s2_q;
    end

    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_det = deb & ~deb_d_q;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_det = ~deb & deb_d_q;
    end else begin : g_any
      assign edge_det = deb ^ deb_d_q;
    end
  endgenerate

  assign deb_o = deb;
  assign cap_o = cap_q;
endmodule

module nios2e_pio_in #(
  parameter int WIDTH        = 28,
  parameter int EDGE_TYPE    = 0,
  parameter int DEBOUNCE_DIV = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  localparam int CW = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;

  logic             tick;
  logic             wr_en;
  logic [WIDTH-1:0] deb, cap, clr;
  logic [WIDTH-1:0] irqmask_q;
  logic [31:0]      readdata_q, readdata_d;

  generate
    if (DEBOUNCE_DIV > 0) begin : g_tick
      logic [CW-1:0] cnt_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                         cnt_q <= '0;
        else if (cnt_q == CW'(DEBOUNCE_DIV-1)) cnt_q <= '0;
        else                                  cnt_q <= cnt_q + CW'(1);
      end
      assign tick = (cnt_q == CW'(DEBOUNCE_DIV-1));
    end else begin : g_notick
      assign tick = 1'b0;
    end
  endgenerate

  assign wr_en = chipselect & ~write_n;
  assign clr   = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  nios2e_pio_in_lane #(
    .EDGE_TYPE (EDGE_TYPE),
    .DEBOUNCE  (DEBOUNCE_DIV > 0)
  ) u_lane [WIDTH-1:0] (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_bit_i (in_port),
    .tick_i   (tick),
    .clr_i    (clr),
    .deb_o    (deb),
    .cap_o    (cap)
  );

  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = deb;
      2'd1:    readdata_d[WIDTH-1:0] = irqmask_q;
      2'd3:    readdata_d[WIDTH-1:0] = cap;
      default: readdata_d = '0;
    endcase
  end

  // readdata is refreshed every cycle; the fabric inserts one read wait state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_q  <= '0;
      readdata_q <= '0;
    end else begin
      if (wr_en && address == 2'd1) irqmask_q <= writedata[WIDTH-1:0];
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(cap & irqmask_q);
endmodule

// File: tb/tb_nios2e_pio_in.sv
// Scoreboard bench for nios2e_pio_in: bypass/rising, debounced, and any-edge instances.

module tb_nios2e_pio_in;
  typedef struct {
    int          dut;
    bit          is_irq;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst_a, rst_b, rst_c;
  logic [1:0]  address;
  logic        chipselect, write_n;
  logic [31:0] writedata;
  logic [27:0] in_a, in_b, in_c;
  logic [31:0] rd_a, rd_b, rd_c;
  logic        irq_a, irq_b, irq_c;
  logic        obs_vld;

  exp_t        q[$];
  exp_t        mon_e;
  logic [31:0] act;
  int          checks = 0;
  int          errors = 0;

  nios2e_pio_in #(.WIDTH(28), .EDGE_TYPE(0), .DEBOUNCE_DIV(0)) u_a (
    .clk(clk), .reset_n(rst_a), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_a),
    .readdata(rd_a), .irq(irq_a));

  nios2e_pio_in #(.WIDTH(28), .EDGE_TYPE(0), .DEBOUNCE_DIV(4)) u_b (
    .clk(clk), .reset_n(rst_b), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_b),
    .readdata(rd_b), .irq(irq_b));

  nios2e_pio_in #(.WIDTH(28), .EDGE_TYPE(2), .DEBOUNCE_DIV(0)) u_c (
    .clk(clk), .reset_n(rst_c), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_c),
    .readdata(rd_c), .irq(irq_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: pops one expectation per cycle the bench marks as observable
  always @(negedge clk) begin
    if (obs_vld) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: observation with no expected value");
      end else begin
        mon_e = q.pop_front();
        case (mon_e.dut)
          0:       act = mon_e.is_irq ? {31'b0, irq_a} : rd_a;
          1:       act = mon_e.is_irq ? {31'b0, irq_b} : rd_b;
          default: act = mon_e.is_irq ? {31'b0, irq_c} : rd_c;
        endcase
        if (act !== mon_e.val) begin
          errors++;
          $display("FAIL %s: got %h expected %h", mon_e.name, act, mon_e.val);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input int d, input bit is_irq, input logic [31:0] v, input string nm);
    exp_t e;
    e.dut = d; e.is_irq = is_irq; e.val = v; e.name = nm;
    q.push_back(e);
    obs_vld = 1'b1;
    @(posedge clk);
    #1;
    obs_vld = 1'b0;
  endtask

  task automatic rd(input int d, input logic [1:0] a, input logic [31:0] v, input string nm);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    cyc(1);
    chk(d, 1'b0, v, nm);
    chipselect = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = v;
    cyc(1);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  initial begin
    rst_a = 0; rst_b = 0; rst_c = 0;
    address = 0; chipselect = 0; write_n = 1; writedata = 0;
    in_a = 0; in_b = 0; in_c = 0; obs_vld = 0;
    cyc(3);

    // bypass, rising edges
    rst_a = 1; cyc(2);
    rd(0, 2'd0, 32'h0, "a_rst_data");
    rd(0, 2'd3, 32'h0, "a_rst_edgecap");
    rd(0, 2'd1, 32'h0, "a_rst_mask");
    chk(0, 1'b1, 32'h0, "a_rst_irq");
    wr(2'd1, 32'h1);
    rd(0, 2'd1, 32'h1, "a_mask_readback");
    in_a[0] = 1'b1; cyc(2);
    chk(0, 1'b1, 32'h0, "a_irq_before_E2");
    chk(0, 1'b1, 32'h1, "a_irq_after_E2");
    rd(0, 2'd3, 32'h1, "a_edgecap_bit0");
    rd(0, 2'd0, 32'h1, "a_data_bit0");
    in_a[0] = 1'b0; cyc(4);
    rd(0, 2'd3, 32'h1, "a_fall_ignored");
    in_a[0] = 1'b1; cyc(2);
    wr(2'd3, 32'h1);
    chk(0, 1'b1, 32'h1, "a_collision_irq");
    rd(0, 2'd3, 32'h1, "a_collision_cap");
    wr(2'd3, 32'h1);
    chk(0, 1'b1, 32'h0, "a_clear_irq");
    rd(0, 2'd3, 32'h0, "a_clear_cap");
    in_a[5] = 1'b1; cyc(4);
    chk(0, 1'b1, 32'h0, "a_mask_gate_irq");
    rd(0, 2'd3, 32'h20, "a_mask_gate_cap");
    wr(2'd1, 32'h21);
    chk(0, 1'b1, 32'h1, "a_mask_open_irq");
    wr(2'd1, 32'hF000_0021);
    rd(0, 2'd1, 32'h21, "a_mask_high_bits");
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd2, 32'hFFFF_FFFF);
    rd(0, 2'd0, 32'h21, "a_data_readonly");
    rd(0, 2'd2, 32'h0, "a_reserved");
    in_a[27] = 1'b1; cyc(3);
    rd(0, 2'd0, 32'h0800_0021, "a_data_msb");

    // debounced, period 4
    rst_b = 1; cyc(2);
    wr(2'd1, 32'h4);
    in_b[2] = 1'b1; cyc(3);
    in_b[2] = 1'b0; cyc(12);
    rd(1, 2'd0, 32'h0, "b_glitch_data");
    rd(1, 2'd3, 32'h0, "b_glitch_cap");
    chk(1, 1'b1, 32'h0, "b_glitch_irq");
    in_b[2] = 1'b1; cyc(12);
    rd(1, 2'd0, 32'h4, "b_stable_data");
    rd(1, 2'd3, 32'h4, "b_stable_cap");
    chk(1, 1'b1, 32'h1, "b_stable_irq");
    wr(2'd3, 32'h4); cyc(12);
    rd(1, 2'd3, 32'h0, "b_single_edge");
    chk(1, 1'b1, 32'h0, "b_single_edge_irq");

    // any edge, then reset mid-operation
    rst_c = 1; cyc(2);
    wr(2'd1, 32'h2);
    in_c[1] = 1'b1; cyc(4);
    rd(2, 2'd3, 32'h2, "c_rise_cap");
    wr(2'd3, 32'h2);
    rd(2, 2'd3, 32'h0, "c_cleared");
    in_c[1] = 1'b0; cyc(4);
    rd(2, 2'd3, 32'h2, "c_fall_cap");
    chk(2, 1'b1, 32'h1, "c_irq");
    address = 2'd3; chipselect = 1'b0; cyc(2);
    chk(2, 1'b0, 32'h2, "c_pre_rst_readdata");
    rst_c = 1'b0;
    chk(2, 1'b0, 32'h0, "c_rst_readdata");
    rst_c = 1'b1;
    chk(2, 1'b1, 32'h0, "c_rst_irq");
    rd(2, 2'd3, 32'h0, "c_rst_edgecap");
    rd(2, 2'd1, 32'h0, "c_rst_mask");
    rd(2, 2'd0, 32'h0, "c_rst_data");

    cyc(2);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d expectations never observed", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nios2e_pio_in.md
# nios2e_pio_in

Avalon-MM slave input port that samples external signals onto the Nios II data bus. It is the read-side counterpart to the output decode/PIO registers that drive board outputs. It synchronizes and optionally debounces an input bus, exposes its level, captures edges into sticky write-1-to-clear bits and raises a maskable interrupt. It sits on the system interconnect beside the output PIOs and feeds the CPU IRQ line.

## Interface
- WIDTH, 28: number of input bits (1..32).
- EDGE_TYPE, 0: capture mode; 0 rising, 1 falling, 2 any edge.
- DEBOUNCE_DIV, 0: debounce tick period in clk cycles; 0 bypasses the debouncer.
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data; upper 32-WIDTH bits are 0.
- irq  out  1  level interrupt, active-high.

## Operation
- Register map:
  - 0 DATA: read-only; returns the debounced level. Writes are ignored.
  - 1 IRQMASK: read/write WIDTH bits.
  - 2 reserved: reads 0, writes ignored.
  - 3 EDGECAP: read; write-1-to-clear per bit.
- Input path: 2-FF synchronizer per bit (s1, s2). Reset value 0.
- Debounce, when DEBOUNCE_DIV > 0:
  - A free-running counter counts 0..DEBOUNCE_DIV-1 and pulses tick when count = DEBOUNCE_DIV-1, then wraps to 0.
  - On tick, prev <= s2. If s2 == prev, deb <= s2.
  - A level change must therefore persist across two consecutive ticks to propagate.
  - Pulses shorter than one tick period never reach deb.
- Debounce bypassed (DEBOUNCE_DIV = 0): deb = s2 (a wire, no extra register).
- Edge detect: deb_d <= deb every cycle.
  - Rising edge: deb & ~deb_d.
  - Falling edge: ~deb & deb_d.
  - Any edge: deb ^ deb_d.
- Edge capture: edgecap[i] <= 1 on a detected edge and stays set until cleared.
  - Write to address 3 with writedata[i] = 1 clears bit i.
  - Edge and clear on the same bit in the same cycle: bit stays set (edge wins).
- IRQMASK: written on chipselect & ~write_n & address = 1, taking writedata[WIDTH-1:0].
- irq = |(edgecap & irqmask), decoded combinationally from registers.
- Reset values:
  - s1, s2, prev, deb, deb_d, edgecap, irqmask, counter, readdata: all 0.
  - irq: 0.
- Consequence of the zero reset: an input held high through reset produces one rising edge after release. Firmware clears EDGECAP during init.
- Writes outside addresses 1 and 3 have no effect. Writedata bits at WIDTH and above are ignored.

## Timing
- readdata <= mux(address) every clk edge, with no chipselect qualification. Read latency is 1 cycle: the interconnect uses 1 read wait state.
- Bypass mode, with in_port changing before edge E0:
  - s1 is updated at E0; s2/deb are updated at E1.
  - edgecap is set at E2, and irq is high after E2 if masked in.
  - DATA read with address presented at E1 returns the new level in readdata after E2.
- Debounce mode: deb changes 2 to 3 + DEBOUNCE_DIV... more exactly, between 1 and 2 tick periods after s2 changes, plus 2 sync cycles.
- An EDGECAP clear write at edge Ew takes effect after Ew, and irq drops in the same cycle if no other masked bit is set.
- An IRQMASK write also takes effect after the write edge, and irq follows combinationally.
- Reset assertion mid-operation clears all state immediately (asynchronously), including any pending edges and the debounce counter.

## Test plan
- Reset, bypass mode, WIDTH = 28: hold in_port = 0, release reset.
  - Read address 0 -> 0x0000000.
  - Read address 3 -> 0.
  - irq = 0.
- Rising edge, EDGE_TYPE = 0: write IRQMASK = 0x1, drive in_port[0] 0 -> 1 before E0.
  - edgecap[0] = 1 after E2.
  - irq = 1 after E2.
  - Read address 3 -> 0x00000001.
- Clear vs. edge collision: write 0x1 to address 3 on the same edge where a new in_port[0] edge is captured -> bit remains 1 and irq stays high. Then a clean clear write -> 0 and irq low.
- Mask gating: edge on bit 5 with IRQMASK = 0x1.
  - irq stays 0 while edgecap reads 0x20.
  - Writing IRQMASK = 0x21 -> irq = 1 the next cycle.
- Debounce with DEBOUNCE_DIV = 4: 3-cycle glitch on in_port[2] -> DATA unchanged, no edge captured. Level held for 12 cycles -> DATA bit 2 = 1, and exactly one captured edge.
- EDGE_TYPE = 2 and reset mid-operation: toggle bit 1 twice -> edgecap[1] = 1. Assert reset_n low for one cycle -> all registers 0, irq = 0, and readdata = 0 on the next read.
